// File: rtl/dawncarol_key.sv
// dawncarol_key: KEY_NUM push-button conditioner (sync, debounce, strobes).
// Ports: sys_clk, resetn (async, active-low); key_in raw pins;
//   key_state level; key_press/key_release/key_long 1-cycle strobes;
//   key_toggle per-press toggle (built with DAWNCAROL_KEY_TOGGLE_EN).
module dawncarol_key #(
  parameter int unsigned KEY_NUM      = 4,
  parameter int unsigned DEBOUNCE_CNT = 32'd1_000_000,
  parameter int unsigned HOLD_CNT     = 32'd100_000_000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic               sys_clk,
  input  logic               resetn,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_toggle
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned HW = $clog2(HOLD_CNT + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CNT - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CNT);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CNT - 1);

  // Pin level when the key is not pressed.
  localparam logic [KEY_NUM-1:0] IDLE_LVL =
    ACTIVE_LOW ? {KEY_NUM{1'b1}} : {KEY_NUM{1'b0}};

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } key_st_e;

  logic [KEY_NUM-1:0] sync1_q, sync1_d;
  logic [KEY_NUM-1:0] sync2_q, sync2_d;
  logic [KEY_NUM-1:0] k_s;

  key_st_e       st_q   [KEY_NUM];
  key_st_e       st_d   [KEY_NUM];
  logic [DW-1:0] deb_q  [KEY_NUM];
  logic [DW-1:0] deb_d  [KEY_NUM];
  logic [HW-1:0] hold_q [KEY_NUM];
  logic [HW-1:0] hold_d [KEY_NUM];

  logic [KEY_NUM-1:0] lvl_q, lvl_d;
  logic [KEY_NUM-1:0] press_q, press_d;
  logic [KEY_NUM-1:0] rel_q, rel_d;
  logic [KEY_NUM-1:0] long_q, long_d;
  // Set once key_long has fired for the current press, so a release
  // glitch that re-enters PRESSED cannot fire it a second time.
  logic [KEY_NUM-1:0] done_q, done_d;

  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
  end

  assign k_s = ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    deb_d   = deb_q;
    hold_d  = hold_q;
    lvl_d   = lvl_q;
    done_d  = done_q;
    press_d = '0;
    rel_d   = '0;
    long_d  = '0;
    for (int i = 0; i < int'(KEY_NUM); i++) begin
      unique case (st_q[i])
        RELEASED: begin
          if (k_s[i]) begin
            st_d[i]  = PRESS_DB;
            deb_d[i] = '0;
          end
        end
        PRESS_DB: begin
          if (!k_s[i]) begin
            st_d[i]  = RELEASED;
            deb_d[i] = '0;
          end else if (deb_q[i] == DEB_LAST) begin
            st_d[i]    = PRESSED;
            lvl_d[i]   = 1'b1;
            press_d[i] = 1'b1;
            hold_d[i]  = '0;
            done_d[i]  = 1'b0;
          end else begin
            deb_d[i] = deb_q[i] + 1'b1;
          end
        end
        PRESSED: begin
          if (!k_s[i]) begin
            st_d[i]   = RELEASE_DB;
            deb_d[i]  = '0;
            hold_d[i] = '0;
          end else begin
            if (hold_q[i] != HOLD_MAX) begin
              hold_d[i] = hold_q[i] + 1'b1;
            end
            if (hold_q[i] == HOLD_LAST && !done_q[i]) begin
              long_d[i] = 1'b1;
              done_d[i] = 1'b1;
            end
          end
        end
        RELEASE_DB: begin
          if (k_s[i]) begin
            st_d[i]  = PRESSED;
            deb_d[i] = '0;
          end else if (deb_q[i] == DEB_LAST) begin
            st_d[i]  = RELEASED;
            lvl_d[i] = 1'b0;
            rel_d[i] = 1'b1;
          end else begin
            deb_d[i] = deb_q[i] + 1'b1;
          end
        end
        default: begin
          st_d[i] = RELEASED;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(KEY_NUM); i++) begin
        st_q[i]   <= RELEASED;
        deb_q[i]  <= '0;
        hold_q[i] <= '0;
      end
      lvl_q   <= '0;
      done_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
    end else begin
      for (int i = 0; i < int'(KEY_NUM); i++) begin
        st_q[i]   <= st_d[i];
        deb_q[i]  <= deb_d[i];
        hold_q[i] <= hold_d[i];
      end
      lvl_q   <= lvl_d;
      done_q  <= done_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  assign key_state   = lvl_q;
  assign key_press   = press_q;
  assign key_release = rel_q;
  assign key_long    = long_q;

`ifdef DAWNCAROL_KEY_TOGGLE_EN
  logic [KEY_NUM-1:0] tog_q, tog_d;

  // Flips on the same edge that raises key_press.
  always_comb begin
    tog_d = tog_q ^ press_d;
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      tog_q <= '0;
    end else begin
      tog_q <= tog_d;
    end
  end

  assign key_toggle = tog_q;
`else
  assign key_toggle = '0;
`endif

endmodule

// File: tb/tb_dawncarol_key.sv
// tb_dawncarol_key: directed and random checks of dawncarol_key
// against a run-length reference model (DEBOUNCE_CNT=4, HOLD_CNT=16).
module tb_dawncarol_key;

  localparam int N = 4;
  localparam int D = 4;
  localparam int H = 16;

  logic         sys_clk = 1'b0;
  logic         resetn;
  logic [N-1:0] key_in;
  logic [N-1:0] key_state;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] key_long;
  logic [N-1:0] key_toggle;

  int errors = 0;
  int checks = 0;

  dawncarol_key #(
    .KEY_NUM     (N),
    .DEBOUNCE_CNT(D),
    .HOLD_CNT    (H),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .sys_clk    (sys_clk),
    .resetn     (resetn),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_toggle (key_toggle)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: pin history delayed two edges, then a level flips
  // once D+1 consecutive samples disagree with it.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_lvl, m_press, m_rel, m_long, m_tog;
  int           opp_run [N];
  int           hold_run[N];
  bit           long_done[N];

  task automatic model_reset();
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
    m_lvl   = '0;
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    m_tog   = '0;
    for (int i = 0; i < N; i++) begin
      opp_run[i]   = 0;
      hold_run[i]  = 0;
      long_done[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] ks;
    if (!resetn) begin
      model_reset();
      return;
    end
    ks = hist.pop_front();
    hist.push_back(~key_in);
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    for (int i = 0; i < N; i++) begin
      if (ks[i] != m_lvl[i]) opp_run[i]++;
      else opp_run[i] = 0;
      if (opp_run[i] == D + 1) begin
        opp_run[i] = 0;
        m_lvl[i]   = ks[i];
        if (ks[i]) begin
          m_press[i]   = 1'b1;
          m_tog[i]     = ~m_tog[i];
          hold_run[i]  = 1;
          long_done[i] = 1'b0;
        end else begin
          m_rel[i] = 1'b1;
        end
      end else if (m_lvl[i]) begin
        if (ks[i]) begin
          hold_run[i]++;
          if (hold_run[i] == H + 1 && !long_done[i]) begin
            m_long[i]    = 1'b1;
            long_done[i] = 1'b1;
          end
        end else begin
          hold_run[i] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [N-1:0] tog_exp;
    @(posedge sys_clk);
    model_edge();
    #1;
`ifdef DAWNCAROL_KEY_TOGGLE_EN
    tog_exp = m_tog;
`else
    tog_exp = '0;
`endif
    chk("state", 32'(key_state), 32'(m_lvl));
    chk("press", 32'(key_press), 32'(m_press));
    chk("release", 32'(key_release), 32'(m_rel));
    chk("long", 32'(key_long), 32'(m_long));
    chk("toggle", 32'(key_toggle), 32'(tog_exp));
  endtask

  initial begin
    int n;
    int m;
    int first;
    int prob;
    logic [N-1:0] tg;

    key_in = '1;
    resetn = 1'b0;
    model_reset();
    repeat (3) cyc();
    chk("reset_outs",
        {key_state, key_press, key_release, key_long, key_toggle}, 0);
    resetn = 1'b1;
    repeat (5) cyc();

    // Clean press on key 0.
    key_in[0] = 1'b0;
    n = 0;
    while (!key_press[0] && n < 20) begin
      cyc();
      n++;
    end
    chk("kp0_latency", n, 7);
    chk("kp0_state", 32'(key_state[0]), 1);
    cyc();
    chk("kp0_one_cycle", 32'(key_press[0]), 0);

    // Bounce on key 1.
    key_in[1] = 1'b0;
    repeat (3) cyc();
    key_in[1] = 1'b1;
    cyc();
    key_in[1] = 1'b0;
    n = 0;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (key_press[1]) begin
        n++;
        if (first == 0) first = k;
      end
    end
    chk("kp1_count", n, 1);
    chk("kp1_latency", first, 7);

    // Long press and release on key 2.
    key_in[2] = 1'b0;
    n = 0;
    while (!key_press[2] && n < 20) begin
      cyc();
      n++;
    end
    chk("kp2_latency", n, 7);
    n = 0;
    first = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (key_long[2]) begin
        n++;
        if (first == 0) first = k;
      end
    end
    chk("kl2_count", n, 1);
    chk("kl2_pos", first, 16);
    key_in[2] = 1'b1;
    n = 0;
    while (!key_release[2] && n < 20) begin
      cyc();
      n++;
    end
    chk("kr2_latency", n, 7);
    chk("kr2_state", 32'(key_state[2]), 0);

    // Release glitch on key 3.
    key_in[3] = 1'b0;
    repeat (10) cyc();
    chk("k3_pressed", 32'(key_state[3]), 1);
    key_in[3] = 1'b1;
    repeat (2) cyc();
    key_in[3] = 1'b0;
    n = 0;
    m = 0;
    for (int k = 0; k < 15; k++) begin
      cyc();
      if (key_release[3]) n++;
      if (key_press[3]) m++;
    end
    chk("k3_no_release", n, 0);
    chk("k3_no_repress", m, 0);
    chk("k3_state", 32'(key_state[3]), 1);

    // Reset during PRESS_DB on key 0 while other keys are held.
    key_in[0] = 1'b1;
    repeat (10) cyc();
    key_in[0] = 1'b0;
    repeat (4) cyc();
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("async_reset",
        {key_state, key_press, key_release, key_long, key_toggle}, 0);
    key_in = '1;
    repeat (3) cyc();
    resetn = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      n += $countones(key_press | key_release | key_long);
    end
    chk("post_reset_quiet", n, 0);

    // Three presses of key 0 for the toggle output.
    for (int p = 0; p < 3; p++) begin
      key_in[0] = 1'b0;
      n = 0;
      while (!key_press[0] && n < 20) begin
        cyc();
        n++;
      end
      chk("tog_press_latency", n, 7);
`ifdef DAWNCAROL_KEY_TOGGLE_EN
      tg = (p == 1) ? 4'h0 : 4'h1;
`else
      tg = '0;
`endif
      chk("toggle0", 32'(key_toggle[0]), 32'(tg[0]));
      key_in[0] = 1'b1;
      repeat (12) cyc();
    end

    // Random pin activity at three bounce densities.
    for (int seg = 0; seg < 15; seg++) begin
      case (seg % 3)
        0: prob = 3;
        1: prob = 10;
        default: prob = 40;
      endcase
      for (int k = 0; k < 200; k++) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(prob - 1) == 0) key_in[i] = ~key_in[i];
        end
        cyc();
      end
    end
    key_in = '1;
    repeat (40) cyc();
    chk("final_released", 32'(key_state), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dawncarol_key.md
Name: dawncarol_key

Overview:
- Input-side companion to the dawncarol_led output block: conditions KEY_NUM raw push-button pins from the board into clean, single-clock event strobes for control logic.
- Per key: 2-FF synchroniser, 4-state debounce FSM, press/release strobes, long-press detection.
- Sits between the board key pins and user logic on the single system clock.

Parameters:
- KEY_NUM, 4: number of independent keys.
- DEBOUNCE_CNT, 32'd1_000_000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range >= 1.
- HOLD_CNT, 32'd100_000_000: cycles in PRESSED before key_long fires (1 s at 100 MHz); must be >= 1.
- ACTIVE_LOW, 1'b1: 1 means a pin reads 0 when pressed; 0 means a pin reads 1 when pressed.

Ports:
- sys_clk  input  1  system clock; the only clock.
- resetn  input  1  asynchronous active-low reset.
- key_in  input  KEY_NUM  raw asynchronous key pins.
- key_state  output  KEY_NUM  debounced level; 1 means pressed.
- key_press  output  KEY_NUM  1-cycle strobe on accepted press.
- key_release  output  KEY_NUM  1-cycle strobe on accepted release.
- key_long  output  KEY_NUM  1-cycle strobe once per press after HOLD_CNT cycles held.
- key_toggle  output  KEY_NUM  toggle per press (see Optional Feature).

Behaviour:
- One clock (sys_clk); reset is asynchronous, active-low (resetn). All flops are cleared on resetn=0 regardless of clock.
- Reset values:
  - all outputs 0;
  - every FSM in RELEASED;
  - all counters 0;
  - synchroniser flops hold the not-pressed level (1 if ACTIVE_LOW, else 0). No spurious strobe is allowed after reset release.
- Synchroniser: 2 flops per key, then polarity normalisation; the result is k_s (1 = pressed).
- Counter widths: deb_cnt is $clog2(DEBOUNCE_CNT+1) bits; hold_cnt is $clog2(HOLD_CNT+1) bits. Counters never wrap.
- FSM per key; states are RELEASED, PRESS_DB, PRESSED, RELEASE_DB.
- RELEASED:
  - k_s=1 -> PRESS_DB, deb_cnt<=0.
- PRESS_DB:
  - k_s=0 -> RELEASED, deb_cnt<=0 (a bounce restarts the count).
  - k_s=1 and deb_cnt==DEBOUNCE_CNT-1 -> PRESSED; same edge sets key_state<=1 and key_press<=1.
  - Otherwise deb_cnt++.
- PRESSED:
  - k_s=0 -> RELEASE_DB, deb_cnt<=0, hold_cnt<=0.
  - Otherwise hold_cnt increments and saturates at HOLD_CNT.
  - When hold_cnt==HOLD_CNT-1, key_long<=1 for exactly one cycle. There is no repeat until the key is released and pressed again.
- RELEASE_DB:
  - k_s=1 -> PRESSED, deb_cnt<=0, hold_cnt stays 0; no strobes.
  - k_s=0 and deb_cnt==DEBOUNCE_CNT-1 -> RELEASED; key_state<=0, key_release<=1.
  - Otherwise deb_cnt++.
- key_state is still 1 throughout RELEASE_DB.
- Strobes are registered and high for exactly one cycle. key_press and key_long on the same key are never high in the same cycle.
- Latency, pin to strobe: key_press/key_release rise DEBOUNCE_CNT+3 clock edges after the first edge that samples the new pin level, provided the pin stays stable.
- Keys are fully independent; simultaneous events on several keys produce simultaneous strobes.
- Reset mid-debounce or mid-hold: state is lost, and no release strobe is generated afterwards.

Optional Feature:
- Macro: DAWNCAROL_KEY_TOGGLE_EN.
- Defined: key_toggle[i] is a register, reset 0, inverted on every key_press[i] strobe; it can drive an LED directly.
- Undefined: key_toggle is tied to constant 0 and no toggle flops are built.
- Port list is identical in both cases.

Test Plan:
- Clean press, DEBOUNCE_CNT=4, ACTIVE_LOW=1: key_in[0] 1->0 and held -> key_press[0]=1 for one cycle, 7 edges after first sample; key_state[0]=1.
- Bounce: key_in[1] low 3 cycles, high 1 cycle, then low and held -> exactly one key_press[1]. Its timing counts from the final low transition; no strobe during the bounce.
- Release and long press, HOLD_CNT=16: hold key 2 for 30 cycles after key_press -> key_long[2] is a single 1-cycle pulse 16 cycles after key_press; then release -> key_release[2] after 7 edges, key_state[2]=0.
- Release glitch: pressed key 3 goes high for 2 cycles and returns low -> no key_release, key_state stays 1, no second key_press.
- Reset mid-operation: resetn=0 during PRESS_DB on key 0 -> all outputs 0 immediately (asynchronous); after resetn=1 with key released -> no strobes.
- With DAWNCAROL_KEY_TOGGLE_EN defined: 3 presses of key 0 -> key_toggle[0] goes 1,0,1. Without it -> key_toggle==0 always.
